// File: rtl/i2c_slave_read_bit_pkg.sv
// Shared I2C bit codes (common to bit writer and reader) and reader FSM states.
package i2c_slave_read_bit_pkg;

  typedef enum logic [2:0] {
    BIT_IDLE  = 3'b000,
    BIT_START = 3'b010,
    BIT_STOP  = 3'b011,
    BIT_DATA0 = 3'b100,
    BIT_DATA1 = 3'b101
  } bit_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one asynchronous bus pin and flags its edges on the synchronized level.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  // Reset to the bus-idle level so a released bus never looks like an edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync <= '1;
      r_dly  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/i2c_slave_read_bit.sv
// Observe-only I2C bit decoder: reports START, STOP, DATA_0 or DATA_1 with a one-clock finish pulse.
module i2c_slave_read_bit
  import i2c_slave_read_bit_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_go,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_finish,
  output logic [2:0] o_bit_type
);

  logic w_scl_s, w_scl_rise, w_scl_fall;
  logic w_sda_s, w_sda_rise, w_sda_fall;

  rd_state_e  r_state;
  logic       r_finish;
  logic [2:0] r_bit_type;
  logic       r_sample;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .i_clock(i_clock), .i_reset(i_reset), .i_pin(i_scl),
    .o_level(w_scl_s), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .i_clock(i_clock), .i_reset(i_reset), .i_pin(i_sda),
    .o_level(w_sda_s), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_finish   <= 1'b0;
      r_bit_type <= BIT_IDLE;
      r_sample   <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      if (!i_go && r_state != ST_DONE) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= w_scl_s ? ST_ARMED : ST_LOW;
          // scl fall is checked first so a coincident sda edge is not a START/STOP.
          ST_ARMED: begin
            if (w_scl_fall) begin
              r_state <= ST_LOW;
            end else if (w_sda_fall) begin
              r_bit_type <= BIT_START;
              r_finish   <= 1'b1;
              r_state    <= ST_DONE;
            end else if (w_sda_rise) begin
              r_bit_type <= BIT_STOP;
              r_finish   <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
          ST_LOW: begin
            if (w_scl_rise) begin
              r_sample <= w_sda_s;
              r_state  <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (w_scl_fall) begin
              r_bit_type <= r_sample ? BIT_DATA1 : BIT_DATA0;
              r_finish   <= 1'b1;
              r_state    <= ST_DONE;
            end else if (w_sda_fall) begin
              r_bit_type <= BIT_START;
              r_finish   <= 1'b1;
              r_state    <= ST_DONE;
            end else if (w_sda_rise) begin
              r_bit_type <= BIT_STOP;
              r_finish   <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_finish   = r_finish;
  assign o_bit_type = r_bit_type;

endmodule

// File: tb/tb_i2c_slave_read_bit.sv
// Directed bench for the I2C bit reader at SYNC_STAGES=2.
module tb_i2c_slave_read_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go  = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       finish;
  logic [2:0] bit_type;

  int tests = 0;
  int fails = 0;
  int fin_cnt = 0;
  logic [2:0] codes[$];
  logic prev_fin = 1'b0;

  always #5 clk = ~clk;

  i2c_slave_read_bit #(.SYNC_STAGES(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_go(go), .i_scl(scl), .i_sda(sda),
    .o_finish(finish), .o_bit_type(bit_type)
  );

  // Records every finish pulse and checks that each lasts exactly one cycle.
  always @(negedge clk) begin
    if (finish) begin
      fin_cnt++;
      codes.push_back(bit_type);
      tests++;
      assert (prev_fin === 1'b0) else begin
        fails++;
        $error("FAIL pulse_width: observed finish high 2 cycles, expected 1");
      end
    end
    prev_fin = finish;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic c, input logic d);
    scl = c;
    sda = d;
    hold(8);
  endtask

  int base;
  logic [7:0] byte_v;
  logic [2:0] exp_seq [10];

  initial begin
    // reset state
    hold(3);
    chk("rst_finish", finish, 0);
    chk("rst_bit_type", bit_type, 0);
    rst = 1'b0;
    go  = 1'b1;
    hold(8);
    chk("idle_no_finish", fin_cnt, 0);

    // START with latency check: finish appears 2 edges after sampling edge
    sda = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("lat_e0", finish, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_e1", finish, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_e2_finish", finish, 1);
    chk("lat_e2_code", bit_type, 3'b010);
    @(posedge clk); @(negedge clk);
    chk("lat_e3", finish, 0);
    hold(6);
    chk("start_cnt", fin_cnt, 1);

    // DATA_1 then DATA_0
    bus(0, 0);
    bus(0, 1);
    bus(1, 1);
    bus(0, 1);
    chk("d1_cnt", fin_cnt, 2);
    chk("d1_code", bit_type, 3'b101);
    bus(0, 0);
    bus(1, 0);
    bus(0, 0);
    chk("d0_cnt", fin_cnt, 3);
    chk("d0_code", bit_type, 3'b100);

    // STOP: scl high with sda low, then sda rises
    bus(1, 0);
    bus(1, 1);
    chk("stop_cnt", fin_cnt, 4);
    chk("stop_code", bit_type, 3'b011);

    // scl and sda fall together in HIGH with sample=1 -> data bit wins
    bus(0, 1);
    bus(1, 1);
    bus(0, 0);
    chk("tie_cnt", fin_cnt, 5);
    chk("tie_code", bit_type, 3'b101);

    // go dropped in HIGH, then sda fall -> nothing reported
    bus(0, 1);
    bus(1, 1);
    go = 1'b0;
    hold(8);
    bus(1, 0);
    chk("abort_cnt", fin_cnt, 5);
    chk("abort_code", bit_type, 3'b101);

    // reset pulsed while in LOW -> outputs cleared, no finish
    go = 1'b1;
    bus(0, 0);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    chk("midrst_code", bit_type, 0);
    chk("midrst_finish", finish, 0);
    hold(8);
    chk("midrst_cnt", fin_cnt, 5);

    // return to bus idle with detection parked
    go = 1'b0;
    bus(1, 1);
    go = 1'b1;
    hold(8);
    chk("park_cnt", fin_cnt, 5);

    // START, byte 10110010, STOP with go held high
    base = codes.size();
    exp_seq = '{3'b010, 3'b101, 3'b100, 3'b101, 3'b101,
                3'b100, 3'b100, 3'b101, 3'b100, 3'b011};
    byte_v = 8'b10110010;
    bus(1, 0);
    for (int i = 7; i >= 0; i--) begin
      bus(0, sda);
      bus(0, byte_v[i]);
      bus(1, byte_v[i]);
    end
    bus(0, sda);
    bus(0, 0);
    bus(1, 0);
    bus(1, 1);
    chk("seq_len", codes.size() - base, 10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < codes.size())
        chk($sformatf("seq_code%0d", i), codes[base + i], exp_seq[i]);
      else
        chk($sformatf("seq_code%0d", i), -1, exp_seq[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave_read_bit.md
I2C_SLAVE_READ_BIT -- requirements
Module: I2C_slave_read_bit

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each of scl and sda; legal values 2..4.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 go  input  1  high = detect one bus bit; low = abort and idle.
REQ-005 scl  input  1  asynchronous I2C clock line, sampled only.
REQ-006 sda  input  1  asynchronous I2C data line, sampled only.
REQ-007 finish  output  1  registered one-clock pulse: a bit has been decoded.
REQ-008 bit_type  output  3  decoded bit code, valid from the finish pulse until the next finish pulse.

Function
REQ-009 Bit codes SHALL be: IDLE 3'b000, START_BIT 3'b010, STOP_BIT 3'b011, DATA_0 3'b100, DATA_1 3'b101, identical to the codes used by the bit writer.
REQ-010 scl and sda SHALL each pass through SYNC_STAGES flops (scl_s, sda_s), with one further delay flop each (scl_d, sda_d) for edge detection.
REQ-011 Edges: rise = s & ~d, fall = ~s & d, evaluated every cycle on the synchronized signals.
REQ-012 FSM states SHALL be IDLE, ARMED, LOW, HIGH, DONE.
REQ-013 IDLE: if go=1, move to ARMED when scl_s=1, else to LOW.
REQ-014 ARMED (scl high, no valid sample): sda fall -> START_BIT; sda rise -> STOP_BIT; scl fall -> LOW.
REQ-015 LOW: scl rise -> capture sda_s into sample register, move to HIGH.
REQ-016 HIGH: sda fall -> START_BIT; sda rise -> STOP_BIT; scl fall -> DATA_0 or DATA_1 per sample register.
REQ-017 On decode, bit_type SHALL be loaded, finish SHALL be 1 for exactly the next cycle (state DONE), and the FSM SHALL return to IDLE.
REQ-018 Latency: finish SHALL rise SYNC_STAGES clock edges after the edge that first samples the deciding pin transition.
REQ-019 Simultaneous scl fall and sda edge in one cycle (ARMED/HIGH): scl fall wins, so the result is a data bit, or LOW from ARMED.
REQ-020 Simultaneous scl rise and sda change in LOW: the sample SHALL take the post-change sda_s value.
REQ-021 go=0 in any state other than DONE SHALL return the FSM to IDLE next cycle, with no finish and bit_type unchanged.
REQ-022 Back-to-back: with go held high, detection of the next bit SHALL start in the cycle after DONE (IDLE re-evaluates scl_s).
REQ-023 No outputs drive the bus; the block is observe-only.

Reset
REQ-024 Reset values: state IDLE; finish 0; bit_type 3'b000; sample 0; all synchronizer and delay flops 1 (bus-idle level).
REQ-025 Reset asserted mid-bit SHALL discard the bit: no finish in the cycle after reset deasserts.

Structure
REQ-026 Bit-code constants SHALL live in the shared I2C defines package/include used by both writer and reader.
REQ-027 Synchronizer plus edge detector SHALL be a sub-module I2C_sync_edge (parameter SYNC_STAGES; outputs level, rise, fall), instantiated once each for scl and sda.
REQ-028 FSM and output registers SHALL be in I2C_slave_read_bit; expected total 120-250 lines of RTL.

Verification (SYNC_STAGES=2, pins held at least 8 clocks per phase)
REQ-029 Bus 11, go=1, sda drops to 0 -> one finish pulse, bit_type=3'b010, 2 edges after sampling.
REQ-030 scl 0 -> sda 1 -> scl 1 -> scl 0 -> finish, bit_type=3'b101; repeat with sda 0 -> bit_type=3'b100.
REQ-031 scl 0, sda 0 -> scl 1 -> sda 1 -> finish, bit_type=3'b011, and no data bit reported.
REQ-032 scl and sda both fall on the same clock while in HIGH with sample=1 -> bit_type=3'b101, not START_BIT.
REQ-033 go dropped while in HIGH, then a sda fall -> no finish, bit_type unchanged; reset pulsed while in LOW -> outputs 0, no finish.
REQ-034 go held high across START, eight data bits 10110010, STOP -> finish pulses with codes 010, 101,100,101,101,100,100,101,100, 011, in order.
